led_scan_display: RTL and testbench

- Output-side consumer of the CPU's 32-bit `led_data_o` bus.
- Latches the CPU's LED word and time-multiplexes it as 8 hexadecimal digits onto a common-anode 7-segment display.
- Sits at the board top level between `RiscvCPU` and the display pins.
- Honours the same `pause` control the CPU uses, so the shown value freezes while the core is paused.

---
 rtl/led_scan_display.sv | 102 ++++++++++
 tb/tb_led_scan_display.sv | 137 +++++++++++++
 2 files changed

// File: rtl/led_scan_display.sv
// Eight-digit common-anode hex display driver: shadows the CPU LED word and
// scans one nibble per digit, optionally blanking leading-zero digits.
module led_scan_display #(
  parameter int SCAN_DIV = 16,
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause,
  input  logic [31:0] led_data_i,
  input  logic        load_i,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        changed_o
);

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

  // Active-low gfedcba pattern for one hex nibble.
  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    logic [6:0] seg;
    seg = 7'h7F;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  // A digit above 0 is a leading zero when it and every higher nibble are 0.
  function automatic logic lz_blank(input logic [31:0] word, input logic [2:0] dig);
    logic nonzero;
    nonzero = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i >= int'(dig)) nonzero = nonzero | (word[4*i +: 4] != 4'h0);
    end
    return (dig != 3'd0) && !nonzero;
  endfunction

  logic [31:0] shadow_p0;
  logic [15:0] div_cnt_p0;
  logic [2:0]  idx_p0;
  logic [3:0]  nib_p0;
  logic        blank_p0;
  logic [6:0]  seg_nxt;

  // Stage p0: shadow capture, divider and digit index.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow_p0  <= '0;
      div_cnt_p0 <= '0;
      idx_p0     <= '0;
      changed_o  <= 1'b0;
    end else begin
      if (div_cnt_p0 == DIV_LAST) begin
        div_cnt_p0 <= '0;
        idx_p0     <= idx_p0 + 3'd1;
      end else begin
        div_cnt_p0 <= div_cnt_p0 + 16'd1;
      end
      if (load_i && !pause) begin
        shadow_p0 <= led_data_i;
        changed_o <= (led_data_i != shadow_p0);
      end else begin
        changed_o <= 1'b0;
      end
    end
  end

  always_comb begin
    nib_p0   = shadow_p0[{idx_p0, 2'b00} +: 4];
    blank_p0 = BLANK_LZ && lz_blank(shadow_p0, idx_p0);
    seg_nxt  = blank_p0 ? 7'h7F : hex_seg(nib_p0);
  end

  // Stage p1: registered pin drivers, so segments only change on clock edges.
  always_ff @(posedge clk) begin
    if (!rst) begin
      an_o  <= 8'hFF;
      seg_o <= 7'h7F;
    end else begin
      an_o  <= ~(8'b1 << idx_p0);
      seg_o <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_led_scan_display.sv
// Bench for led_scan_display: two instances (plain and leading-zero blanking)
// compared each cycle against an arithmetic model of the scan.
module tb_led_scan_display;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pause = 1'b0;
  logic [31:0] led_data_i = '0;
  logic        load_i = 1'b0;
  logic [7:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;
  logic        ch_a, ch_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  led_scan_display #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_a (
    .clk(clk), .rst(rst), .pause(pause), .led_data_i(led_data_i), .load_i(load_i),
    .an_o(an_a), .seg_o(seg_a), .changed_o(ch_a)
  );

  led_scan_display #(.SCAN_DIV(2), .BLANK_LZ(1'b1)) dut_b (
    .clk(clk), .rst(rst), .pause(pause), .led_data_i(led_data_i), .load_i(load_i),
    .an_o(an_b), .seg_o(seg_b), .changed_o(ch_b)
  );

  logic [6:0]  hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int          divs [2] = '{4, 2};
  bit          blk  [2] = '{1'b0, 1'b1};
  int          k    [2];
  logic [31:0] sh   [2];
  logic [7:0]  ea   [2];
  logic [6:0]  es   [2];
  logic        ec   [2];

  function automatic logic [6:0] exp_seg(input logic [31:0] s, input int d, input bit bl);
    logic [31:0] upper;
    logic [3:0]  nib;
    upper = s >> (4 * d);
    nib   = upper[3:0];
    if (bl && d > 0 && upper == 32'h0) return 7'h7F;
    return hex_tab[nib];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic p, input logic l, input logic [31:0] dat);
    rst = r; pause = p; load_i = l; led_data_i = dat;
    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      if (!r) begin
        k[c] = 0; sh[c] = '0; ea[c] = 8'hFF; es[c] = 7'h7F; ec[c] = 1'b0;
      end else begin
        int d;
        k[c]++;
        d = ((k[c] - 1) / divs[c]) % 8;
        ea[c] = ~(8'b1 << d);
        es[c] = exp_seg(sh[c], d, blk[c]);
        ec[c] = l && !p && (dat != sh[c]);
        if (l && !p) sh[c] = dat;
      end
    end
    #1;
    check("an_a",  {24'h0, an_a},  {24'h0, ea[0]});
    check("seg_a", {25'h0, seg_a}, {25'h0, es[0]});
    check("chg_a", {31'h0, ch_a},  {31'h0, ec[0]});
    check("an_b",  {24'h0, an_b},  {24'h0, ea[1]});
    check("seg_b", {25'h0, seg_b}, {25'h0, es[1]});
    check("chg_b", {31'h0, ch_b},  {31'h0, ec[1]});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, $urandom);
  endtask

  initial begin
    logic [31:0] rnd;
    logic r, p, l;
    int guard;

    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);

    // first load, then a full scan of all eight digits
    step(1'b1, 1'b0, 1'b1, 32'h1234_5678);
    idle(34);

    // reloading the same word must not pulse changed_o
    step(1'b1, 1'b0, 1'b1, 32'h1234_5678);
    idle(6);

    // pause blocks the load; releasing it lets the load through
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
    step(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
    idle(36);

    // leading-zero blanking on the second instance
    step(1'b1, 1'b0, 1'b1, 32'h0000_00A0);
    idle(34);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0000);
    idle(34);

    // reset mid-scan while the first instance lights digit 5
    step(1'b1, 1'b0, 1'b1, 32'h8765_4321);
    guard = 0;
    while (an_a !== 8'hDF && guard < 64) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      guard++;
    end
    check("reach_digit5", {24'h0, an_a}, 32'h0000_00DF);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    idle(40);

    // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      rnd = $urandom;
      if ($urandom_range(0, 2) == 0) rnd = rnd >> (4 * $urandom_range(0, 8));
      r = ($urandom_range(0, 99) != 0);
      p = ($urandom_range(0, 3) == 0);
      l = ($urandom_range(0, 2) == 0);
      step(r, p, l, rnd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
